// File: rtl/multiplier_3_if.sv
// Start/ready handshake bundle for the sequential signed 8x8 multiplier.
// The master drives the request and operands; the slave returns the product and ready.
interface multiplier_3_if;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] Product;
    logic        ready;

    modport master (output start, output A, output B, input Product, input ready);
    modport slave  (input start, input A, input B, output Product, output ready);
endinterface

// File: rtl/multiplier_3.sv
// Sequential signed 8x8 shift-add multiplier: captures operands on an accepted start,
// runs 8 iterations (LSB first, sign bit subtracts) and publishes the 16-bit product.
module multiplier_3 (
    input  logic           clk,
    input  logic           rst_n,
    multiplier_3_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;
    logic        ready_q, ready_d;
    logic [15:0] partial_s;
    logic [15:0] acc_step_s;

    // Iteration datapath: one partial product per cycle; weight of bit 7 is negative.
    always_comb begin
        partial_s  = {{8{mcand_q[7]}}, mcand_q} << cnt_q;
        acc_step_s = acc_q;
        if (mplier_q[cnt_q]) begin
            if (cnt_q == 3'd7) begin
                acc_step_s = acc_q - partial_s;
            end else begin
                acc_step_s = acc_q + partial_s;
            end
        end else begin
            acc_step_s = acc_q;
        end
    end

    // Next-state and register updates; operands are only looked at on the accepting edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        ready_d   = ready_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.A;
                    mplier_d = bus.B;
                    acc_d    = 16'h0000;
                    cnt_d    = 3'd0;
                    state_d  = BUSY;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            BUSY: begin
                acc_d = acc_step_s;
                if (cnt_q == 3'd7) begin
                    product_d = acc_step_s;
                    cnt_d     = 3'd0;
                    state_d   = IDLE;
                    ready_d   = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
                acc_d   = 16'h0000;
                ready_d = 1'b1;
            end
        endcase
    end

    // State register; an asynchronous reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            mcand_q   <= 8'h00;
            mplier_q  <= 8'h00;
            acc_q     <= 16'h0000;
            product_q <= 16'h0000;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.Product = product_q;
    assign bus.ready   = ready_q;

endmodule

// File: tb/tb_multiplier_3.sv
// Scoreboard bench for multiplier_3: the driver pushes the signed reference product on
// every capture, a monitor pops and compares whenever ready rises.
module tb_multiplier_3;

    logic clk;
    logic rst_n;
    multiplier_3_if bus ();

    multiplier_3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    logic [15:0] exp_q[$];
    bit skip_next;
    logic prev_ready;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a rising ready marks a completed multiply.
    initial begin
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ready = 1'b1;
            end else begin
                if (bus.ready && !prev_ready) begin
                    if (skip_next) begin
                        skip_next = 1'b0;
                    end else if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'(bus.Product), 32'hFFFF_FFFF);
                    end else begin
                        check("scoreboard_product", 32'(bus.Product), 32'(exp_q.pop_front()));
                    end
                end
                prev_ready = bus.ready;
            end
        end
    end

    // Drive one accepted start; returns 1 ns after the capture edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        while (!bus.ready && guard < 30) begin
            @(posedge clk); #1; guard++;
        end
        check("idle_before_start", 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        exp_q.push_back(ref_mul(a, b));
        #1;
        bus.start = 1'b0;
        bus.A = 8'hxx;
        bus.B = 8'hxx;
        check("ready_low_after_capture", 32'(bus.ready), 32'd0);
    endtask

    // Wait for ready with a bound; compare the number of edges taken.
    task automatic wait_done(input int exp_cycles);
        int n;
        n = 0;
        while (!bus.ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        check("busy_cycles", 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [15:0] e;
        n_tests   = 0;
        n_fail    = 0;
        skip_next = 1'b0;
        bus.start = 1'b0;
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        rst_n     = 1'b0;
        #12;
        check("reset_product", 32'(bus.Product), 32'h0000);
        check("reset_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8'd3, 8'd5);
        wait_done(8);
        check("basic_3x5", 32'(bus.Product), 32'h000F);

        issue(8'h80, 8'h80); wait_done(8);
        check("corner_m128_m128", 32'(bus.Product), 32'h4000);
        issue(8'h7F, 8'h80); wait_done(8);
        check("corner_127_m128", 32'(bus.Product), 32'hC080);
        issue(8'hFF, 8'h01); wait_done(8);
        check("corner_m1_1", 32'(bus.Product), 32'hFFFF);
        issue(8'h00, 8'hB3); wait_done(8);
        check("corner_0_m77", 32'(bus.Product), 32'h0000);

        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            e  = ref_mul(ra, rb);
            issue(ra, rb);
            wait_done(8);
            repeat (2) @(posedge clk);
            #1;
            check("random_stable", 32'(bus.Product), 32'(e));
        end

        issue(8'd7, 8'd9);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.A = 8'd2; bus.B = 8'd2;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.A = 8'hxx; bus.B = 8'hxx;
        wait_done(4);
        check("busy_ignore_start", 32'(bus.Product), 32'h003F);
        issue(8'd2, 8'd2); wait_done(8);
        check("restart_2x2", 32'(bus.Product), 32'h0004);

        issue(8'd10, 8'd10);
        repeat (4) @(posedge clk);
        #1;
        skip_next = 1'b1;
        void'(exp_q.pop_back());
        rst_n = 1'b0;
        #1;
        check("abort_product", 32'(bus.Product), 32'h0000);
        check("abort_ready", 32'(bus.ready), 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        skip_next = 1'b0;
        issue(8'd10, 8'd10); wait_done(8);
        check("after_abort_10x10", 32'(bus.Product), 32'h0064);

        bus.A = 8'hFB; bus.B = 8'h06; bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("cont_ready_high", 32'(bus.ready), 32'd1);
            @(posedge clk);
            exp_q.push_back(ref_mul(8'hFB, 8'h06));
            #1;
            check("cont_ready_low", 32'(bus.ready), 32'd0);
            wait_done(8);
            check("cont_product", 32'(bus.Product), 32'hFFE2);
        end
        bus.start = 1'b0;

        repeat (12) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
